// File: rtl/serv_arb_pkg.sv
// Shared definitions for the SERV Wishbone arbiter.
//   arb_state_t        : grant FSM encoding (IDLE / IBUS / DBUS)
//   REQ_I / REQ_D      : requester ids used to remember the last grant
//   ARB_TIMEOUT_CYCLES : default watchdog limit (SERV_ARB_TIMEOUT_EN builds)
package serv_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IBUS = 2'd1,
      DBUS = 2'd2
   } arb_state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int unsigned ARB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/serv_wb_arbiter.sv
// serv_wb_arbiter: shares one Wishbone memory port between the SERV
// instruction bus (already aligned) and data bus.
//
// A registered grant FSM owns the port until the memory acks, then always
// spends one cycle in IDLE so the next winner is chosen cleanly.
//
// Parameters:
//   AW             address width of all buses
//   RR             0 = fixed priority (dbus first), 1 = round robin
//   TIMEOUT_CYCLES watchdog limit (only with SERV_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_ibus_* / o_ibus_*       instruction requester (adr, cyc / rdt, ack)
//   i_dbus_* / o_dbus_*       data requester (adr, dat, sel, we, cyc / rdt, ack)
//   o_wb_mem_* / i_wb_mem_*   shared memory port
//   o_timeout                 sticky watchdog flag (SERV_ARB_TIMEOUT_EN only)
//
// Build option: define SERV_ARB_TIMEOUT_EN to add the stall watchdog, which
// forces a zero-data ack to the owner after TIMEOUT_CYCLES without an ack.
module serv_wb_arbiter
   import serv_arb_pkg::*;
#(
   parameter int unsigned AW             = 32,
   parameter int          RR             = 0,
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   input  logic [AW-1:0] i_dbus_adr,
   input  logic [31:0]   i_dbus_dat,
   input  logic [3:0]    i_dbus_sel,
   input  logic          i_dbus_we,
   input  logic          i_dbus_cyc,
   output logic [31:0]   o_dbus_rdt,
   output logic          o_dbus_ack,
   output logic [AW-1:0] o_wb_mem_adr,
   output logic [31:0]   o_wb_mem_dat,
   output logic [3:0]    o_wb_mem_sel,
   output logic          o_wb_mem_we,
   output logic          o_wb_mem_cyc,
   input  logic [31:0]   i_wb_mem_rdt,
   input  logic          i_wb_mem_ack
`ifdef SERV_ARB_TIMEOUT_EN
   ,output logic         o_timeout
`endif
);

   arb_state_t state, state_nxt;
   logic       last_grant, last_grant_nxt;
   logic       mem_done;
   logic [31:0] rdt_fwd;

   // Winner of a new request; in round robin the last owner loses a tie.
   function automatic arb_state_t arbitrate(input logic icyc,
                                            input logic dcyc,
                                            input logic last);
      arb_state_t g;
      g = IDLE;
      if (icyc && dcyc)
         g = ((RR != 0) && (last == REQ_D)) ? IBUS : DBUS;
      else if (dcyc)
         g = DBUS;
      else if (icyc)
         g = IBUS;
      return g;
   endfunction

`ifdef SERV_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wd_cnt;
   logic          timeout_hit;

   // A real ack in the same cycle takes precedence over the watchdog.
   assign timeout_hit = (state != IDLE) && !i_wb_mem_ack &&
                        (wd_cnt == CW'(TIMEOUT_CYCLES));

   // Every grant passes through IDLE, so clearing there clears per grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
      end else begin
         if (state == IDLE)
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + 1'b1;
         if (timeout_hit)
            o_timeout <= 1'b1;
      end
   end

   assign mem_done = i_wb_mem_ack | timeout_hit;
   assign rdt_fwd  = timeout_hit ? '0 : i_wb_mem_rdt;
`else
   assign mem_done = i_wb_mem_ack;
   assign rdt_fwd  = i_wb_mem_rdt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= REQ_I;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Owner keeps the grant until the ack even if it drops cyc early.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: state_nxt = arbitrate(i_ibus_cyc, i_dbus_cyc, last_grant);
         IBUS, DBUS: begin
            if (mem_done) begin
               state_nxt      = IDLE;
               last_grant_nxt = (state == DBUS) ? REQ_D : REQ_I;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_wb_mem_adr = '0;
      o_wb_mem_dat = '0;
      o_wb_mem_sel = '0;
      o_wb_mem_we  = 1'b0;
      case (state)
         IBUS: o_wb_mem_adr = i_ibus_adr;
         DBUS: begin
            o_wb_mem_adr = i_dbus_adr;
            o_wb_mem_dat = i_dbus_dat;
            o_wb_mem_sel = i_dbus_sel;
            o_wb_mem_we  = i_dbus_we;
         end
         default: ;
      endcase
   end

   assign o_wb_mem_cyc = (state != IDLE);
   assign o_ibus_ack   = mem_done & (state == IBUS);
   assign o_dbus_ack   = mem_done & (state == DBUS);
   assign o_ibus_rdt   = rdt_fwd;
   assign o_dbus_rdt   = rdt_fwd;

endmodule
